up_timer: RTL

//   Memory-mapped down-counting timer and interrupt source on the up

---
 rtl/up_timer_if.sv | 21 ++
 rtl/up_timer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/up_timer_if.sv
// Multiplexed address/data bus between the up processor and the timer target.
// The interrupt line is named intr because int is a reserved word.
interface up_timer_if;
  logic       ale;
  logic [7:0] bus_in;
  logic       re;
  logic       we;
  logic [7:0] bus_out;
  logic       bus_sel;
  logic       intr;

  modport master (
    output ale, bus_in, re, we,
    input  bus_out, bus_sel, intr
  );

  modport slave (
    input  ale, bus_in, re, we,
    output bus_out, bus_sel, intr
  );
endinterface

// File: rtl/up_timer.sv
// Memory-mapped prescaled down-counting timer with auto-reload/one-shot modes
// and a level interrupt, living in a 4-register window on the up bus.
module up_timer #(
  parameter logic [7:0]  BASE_ADDR = 8'hF0,
  parameter int unsigned PS_W      = 6
) (
  input  logic       clk,
  input  logic       rst,
  up_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_RELOAD = 2'd1,
    REG_COUNT  = 2'd2,
    REG_STATUS = 2'd3
  } reg_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e          state, state_nxt;
  logic [7:0]      addr;
  logic            ar, ar_nxt;
  logic            ie, ie_nxt;
  logic [1:0]      ps, ps_nxt;
  logic [7:0]      reload, reload_nxt;
  logic [7:0]      count, count_nxt;
  logic            exp, exp_nxt;
  logic [PS_W-1:0] presc, presc_nxt;
  logic [PS_W-1:0] ps_max;
  logic [7:0]      rdata;
  logic            hit;
  reg_e            off;
  logic            wr_ctrl, wr_reload, wr_count, wr_status;
  logic            tick, tick_eff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr <= '0;
    end else if (bus.ale) begin
      addr <= bus.bus_in;
    end
  end

  assign hit       = (addr[7:2] == BASE_ADDR[7:2]);
  assign off       = reg_e'(addr[1:0]);
  assign wr_ctrl   = bus.we && hit && (off == REG_CTRL);
  assign wr_reload = bus.we && hit && (off == REG_RELOAD);
  assign wr_count  = bus.we && hit && (off == REG_COUNT);
  assign wr_status = bus.we && hit && (off == REG_STATUS);

  // Terminal prescaler value is (1 << 2*PS) - 1: the low 2*PS bits set.
  always_comb begin
    ps_max = '0;
    for (int unsigned i = 0; i < PS_W; i++) begin
      if (i < 32'({ps, 1'b0})) ps_max[i] = 1'b1;
    end
  end

  assign tick = (state == ST_RUN) && (presc == ps_max);
  // A COUNT write or an EN-clearing CTRL write swallows this cycle's tick.
  assign tick_eff = tick && !wr_count && !(wr_ctrl && !bus.bus_in[0]);

  always_comb begin
    state_nxt  = state;
    ar_nxt     = ar;
    ie_nxt     = ie;
    ps_nxt     = ps;
    reload_nxt = reload;
    count_nxt  = count;
    exp_nxt    = exp;
    presc_nxt  = presc;

    if (wr_ctrl) begin
      state_nxt = bus.bus_in[0] ? ST_RUN : ST_IDLE;
      ar_nxt    = bus.bus_in[1];
      ie_nxt    = bus.bus_in[2];
      ps_nxt    = bus.bus_in[4:3];
    end
    if (wr_reload) reload_nxt = bus.bus_in;
    if (wr_count)  count_nxt  = bus.bus_in;
    if (wr_status && bus.bus_in[0]) exp_nxt = 1'b0;

    // Expiry is applied after the W1C so a coincident set wins.
    if (tick_eff) begin
      if (count != 8'h00) begin
        count_nxt = count - 8'h01;
      end else begin
        exp_nxt = 1'b1;
        if (ar) count_nxt = reload;
        else    state_nxt = ST_IDLE;
      end
    end

    if (state_nxt == ST_IDLE) begin
      presc_nxt = '0;
    end else if (wr_ctrl && ((state == ST_IDLE) || (bus.bus_in[4:3] != ps))) begin
      presc_nxt = '0;
    end else if (tick) begin
      presc_nxt = '0;
    end else begin
      presc_nxt = presc + PS_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      ar     <= 1'b0;
      ie     <= 1'b0;
      ps     <= '0;
      reload <= '0;
      count  <= '0;
      exp    <= 1'b0;
      presc  <= '0;
    end else begin
      state  <= state_nxt;
      ar     <= ar_nxt;
      ie     <= ie_nxt;
      ps     <= ps_nxt;
      reload <= reload_nxt;
      count  <= count_nxt;
      exp    <= exp_nxt;
      presc  <= presc_nxt;
    end
  end

  always_comb begin
    rdata = '0;
    case (off)
      REG_CTRL:   rdata = {3'b000, ps, ie, ar, (state == ST_RUN)};
      REG_RELOAD: rdata = reload;
      REG_COUNT:  rdata = count;
      REG_STATUS: rdata = {7'b0000000, exp};
      default:    rdata = '0;
    endcase
  end

  assign bus.bus_sel = bus.re && hit;
  assign bus.bus_out = bus.bus_sel ? rdata : '0;
  assign bus.intr    = exp && ie;

endmodule
